// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared types and constants for the mulit/mulot multiplier interface
//
// Purpose : operand/product widths, default tag width, request/response
//           structs exchanged between fmad mul ports and mul_srv, plus the
//           exact unsigned multiply used by the server pipeline.
package fma_pkg;

    localparam int MUL_W  = 27;
    localparam int PROD_W = 54;
    localparam int TAGW   = 4;

    typedef struct packed {
        logic              req;
        logic [TAGW-1:0]   tag;
        logic [MUL_W-1:0]  a;
        logic [MUL_W-1:0]  b;
    } mulit;

    typedef struct packed {
        logic              ack;
        logic              vld;
        logic [TAGW-1:0]   tag;
        logic [PROD_W-1:0] prod;
    } mulot;

    // Full-width unsigned product: both operands are widened first so no
    // bits are lost before the multiply.
    function automatic logic [PROD_W-1:0] mul_exact(input logic [MUL_W-1:0] a,
                                                    input logic [MUL_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

endpackage

// File: rtl/mul_srv_rr.sv
// rtl/mul_srv_rr.sv - NCLI-way round-robin arbiter for mul_srv
//
// Purpose : grants at most one requester per cycle, scanning from the
//           rotating pointer upwards and wrapping to 0.
// Ports   : clk, reset_n    clock / async active-low reset
//           i_req[NCLI]     request vector
//           o_gnt[NCLI]     one-hot grant (combinational)
//           o_gnt_idx[IW]   index of the granted client (0 when none)
//           o_gnt_vld       a grant is issued this cycle
module mul_srv_rr #(
    parameter int NCLI = 4,
    parameter int IW   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCLI-1:0] i_req,
    output logic [NCLI-1:0] o_gnt,
    output logic [IW-1:0]   o_gnt_idx,
    output logic            o_gnt_vld
);

    logic [IW-1:0] r_ptr;
    int            w_k;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_k       = 0;
        for (int i = 0; i < NCLI; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= NCLI) begin
                w_k = w_k - NCLI;
            end
            if (!o_gnt_vld && i_req[w_k]) begin
                o_gnt_vld  = 1'b1;
                o_gnt_idx  = IW'(w_k);
                o_gnt[w_k] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; it stays put on idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (o_gnt_vld) begin
            r_ptr <= (o_gnt_idx == IW'(NCLI - 1)) ? '0 : o_gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/mul_srv.sv
// rtl/mul_srv.sv - shared 27x27 multiplier server with round-robin clients
//
// Purpose : arbitrates NCLI multiply requests, runs one through a LAT-deep
//           pipeline per cycle and returns prod/tag to the owning client.
// Ports   : clk, reset_n    clock / async active-low reset
//           muli[NCLI]      per-client req, tag, a, b
//           mulo[NCLI]      per-client ack (comb), vld, tag, prod
//           stat_clr        synchronous clear of stat_busy
//           stat_busy[32]   saturating count of granted cycles
// Config  : MUL_SRV_STAT_EN enables the stat_busy counter; otherwise
//           stat_busy is 0 and stat_clr is ignored.
module mul_srv
    import fma_pkg::*;
#(
    parameter int NCLI = 4,
    parameter int LAT  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  mulit        muli [NCLI],
    output mulot        mulo [NCLI],
    input  logic        stat_clr,
    output logic [31:0] stat_busy
);

    localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;

    logic [NCLI-1:0]   w_req;
    logic [NCLI-1:0]   w_gnt;
    logic [IW-1:0]     w_gnt_idx;
    logic              w_gnt_vld;
    logic [TAGW-1:0]   w_sel_tag;
    logic [MUL_W-1:0]  w_sel_a;
    logic [MUL_W-1:0]  w_sel_b;

    // Inputs to the per-client result registers (last pipeline stage).
    logic              w_fin_v;
    logic [IW-1:0]     w_fin_id;
    logic [TAGW-1:0]   w_fin_tag;
    logic [PROD_W-1:0] w_fin_prod;

    for (genvar c = 0; c < NCLI; c++) begin : g_req
        assign w_req[c] = muli[c].req;
    end

    mul_srv_rr #(.NCLI(NCLI), .IW(IW)) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (w_req),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    assign w_sel_tag = muli[w_gnt_idx].tag;
    assign w_sel_a   = muli[w_gnt_idx].a;
    assign w_sel_b   = muli[w_gnt_idx].b;

    if (LAT == 1) begin : g_lat1
        // Single-cycle latency: multiply straight from the operand mux.
        assign w_fin_v    = w_gnt_vld;
        assign w_fin_id   = w_gnt_idx;
        assign w_fin_tag  = w_sel_tag;
        assign w_fin_prod = mul_exact(w_sel_a, w_sel_b);
    end else begin : g_latn
        logic              w_cv    [LAT-1];
        logic [IW-1:0]     w_cid   [LAT-1];
        logic [TAGW-1:0]   w_ctag  [LAT-1];
        logic [PROD_W-1:0] w_cprod [LAT-1];

        logic              r_v0;
        logic [IW-1:0]     r_id0;
        logic [TAGW-1:0]   r_tag0;
        logic [MUL_W-1:0]  r_a0;
        logic [MUL_W-1:0]  r_b0;

        // Stage 0 captures operands on the ack edge.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_v0   <= 1'b0;
                r_id0  <= '0;
                r_tag0 <= '0;
                r_a0   <= '0;
                r_b0   <= '0;
            end else begin
                r_v0 <= w_gnt_vld;
                if (w_gnt_vld) begin
                    r_id0  <= w_gnt_idx;
                    r_tag0 <= w_sel_tag;
                    r_a0   <= w_sel_a;
                    r_b0   <= w_sel_b;
                end
            end
        end

        assign w_cv[0]    = r_v0;
        assign w_cid[0]   = r_id0;
        assign w_ctag[0]  = r_tag0;
        assign w_cprod[0] = mul_exact(r_a0, r_b0);

        for (genvar s = 1; s < LAT - 1; s++) begin : g_stg
            logic              r_v;
            logic [IW-1:0]     r_id;
            logic [TAGW-1:0]   r_tag;
            logic [PROD_W-1:0] r_prod;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_v    <= 1'b0;
                    r_id   <= '0;
                    r_tag  <= '0;
                    r_prod <= '0;
                end else begin
                    r_v    <= w_cv[s-1];
                    r_id   <= w_cid[s-1];
                    r_tag  <= w_ctag[s-1];
                    r_prod <= w_cprod[s-1];
                end
            end

            assign w_cv[s]    = r_v;
            assign w_cid[s]   = r_id;
            assign w_ctag[s]  = r_tag;
            assign w_cprod[s] = r_prod;
        end

        assign w_fin_v    = w_cv[LAT-2];
        assign w_fin_id   = w_cid[LAT-2];
        assign w_fin_tag  = w_ctag[LAT-2];
        assign w_fin_prod = w_cprod[LAT-2];
    end

    // The last stage is split per client so each client's prod/tag hold
    // their value while results for other clients stream past.
    for (genvar c = 0; c < NCLI; c++) begin : g_out
        logic              w_hit;
        logic              r_vld;
        logic [TAGW-1:0]   r_tag;
        logic [PROD_W-1:0] r_prod;

        assign w_hit = w_fin_v && (w_fin_id == IW'(c));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld  <= 1'b0;
                r_tag  <= '0;
                r_prod <= '0;
            end else begin
                r_vld <= w_hit;
                if (w_hit) begin
                    r_tag  <= w_fin_tag;
                    r_prod <= w_fin_prod;
                end
            end
        end

        assign mulo[c] = '{ack: w_gnt[c], vld: r_vld, tag: r_tag, prod: r_prod};
    end

`ifdef MUL_SRV_STAT_EN
    logic [31:0] r_stat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat <= '0;
        end else if (stat_clr) begin
            r_stat <= '0;
        end else if (w_gnt_vld && (r_stat != 32'hFFFF_FFFF)) begin
            r_stat <= r_stat + 32'd1;
        end
    end

    assign stat_busy = r_stat;
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = stat_clr;
    assign stat_busy         = '0;
`endif

endmodule

// File: tb/tb_mul_srv.sv
// tb/tb_mul_srv.sv - directed scoreboard bench for mul_srv
module tb_mul_srv;
    import fma_pkg::*;

    localparam int NCLI = 4;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    mulit        cli_in  [NCLI];
    mulot        cli_out [NCLI];
    logic        stat_clr;
    logic [31:0] stat_busy;

    always #5 clk = ~clk;

    mul_srv #(.NCLI(NCLI), .LAT(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .muli      (cli_in),
        .mulo      (cli_out),
        .stat_clr  (stat_clr),
        .stat_busy (stat_busy)
    );

    typedef struct {
        int                due;
        int                cli;
        logic [TAGW-1:0]   tag;
        logic [PROD_W-1:0] prod;
    } exp_t;

    exp_t              sbq [$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                m_ptr   = 0;
    logic [31:0]       m_stat  = '0;
    logic [TAGW-1:0]   m_tag  [NCLI];
    logic [PROD_W-1:0] m_prod [NCLI];
    bit                keep   [NCLI];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic load(input int c, input logic [TAGW-1:0] tag,
                        input logic [MUL_W-1:0] a, input logic [MUL_W-1:0] b);
        cli_in[c].req = 1'b1;
        cli_in[c].tag = tag;
        cli_in[c].a   = a;
        cli_in[c].b   = b;
    endtask

    task automatic load_rand(input int c);
        load(c, TAGW'($urandom), MUL_W'($urandom), MUL_W'($urandom));
    endtask

    // Called at posedge+1: checks the current cycle mid-way, updates the
    // model, then advances to the next posedge+1 and retires acked requests.
    task automatic tick();
        int   g;
        int   ec;
        exp_t e;
        #4;
        if (!reset_n) begin
            sbq.delete();
            m_ptr  = 0;
            m_stat = '0;
            for (int c = 0; c < NCLI; c++) begin
                m_tag[c]  = '0;
                m_prod[c] = '0;
            end
        end
        g = -1;
        for (int i = 0; i < NCLI; i++) begin
            int k;
            k = (m_ptr + i) % NCLI;
            if (g < 0 && cli_in[k].req) g = k;
        end
        for (int c = 0; c < NCLI; c++) begin
            chk($sformatf("ack%0d@%0d", c, cyc), 64'(cli_out[c].ack), 64'(c == g));
        end
        ec = -1;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e  = sbq.pop_front();
            ec = e.cli;
            m_tag[ec]  = e.tag;
            m_prod[ec] = e.prod;
        end
        for (int c = 0; c < NCLI; c++) begin
            chk($sformatf("vld%0d@%0d", c, cyc), 64'(cli_out[c].vld), 64'(c == ec));
            chk($sformatf("tag%0d@%0d", c, cyc), 64'(cli_out[c].tag), 64'(m_tag[c]));
            chk($sformatf("prod%0d@%0d", c, cyc), 64'(cli_out[c].prod), 64'(m_prod[c]));
        end
        chk($sformatf("stat@%0d", cyc), 64'(stat_busy), 64'(m_stat));
        if (reset_n && g >= 0) begin
            e.due  = cyc + LAT;
            e.cli  = g;
            e.tag  = cli_in[g].tag;
            e.prod = PROD_W'(cli_in[g].a) * PROD_W'(cli_in[g].b);
            sbq.push_back(e);
            m_ptr = (g + 1) % NCLI;
        end
`ifdef MUL_SRV_STAT_EN
        if (reset_n) begin
            if (stat_clr) m_stat = '0;
            else if (g >= 0 && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 32'd1;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
        if (g >= 0) begin
            if (keep[g]) load_rand(g);
            else cli_in[g].req = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        for (int c = 0; c < NCLI; c++) cli_in[c].req = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        stat_clr = 1'b0;
        for (int c = 0; c < NCLI; c++) begin
            cli_in[c] = '0;
            keep[c]   = 1'b0;
            m_tag[c]  = '0;
            m_prod[c] = '0;
        end
        @(posedge clk);
        #1;
        tick();
        tick();
        reset_n = 1'b1;

        // Max operands, product must be exact in 54 bits.
        load(0, 4'hA, 27'h7FF_FFFF, 27'h7FF_FFFF);
        repeat (3) tick();
        chk("t1_prod", 64'(cli_out[0].prod), 64'h3F_FFFF_F000_0001);
        chk("t1_tag", 64'(cli_out[0].tag), 64'hA);

        // All clients requesting continuously from a fresh reset.
        reset_pulse();
        for (int c = 0; c < NCLI; c++) begin
            keep[c] = 1'b1;
            load_rand(c);
        end
        repeat (12) tick();
        for (int c = 0; c < NCLI; c++) begin
            keep[c]        = 1'b0;
            cli_in[c].req  = 1'b0;
        end
        repeat (3) tick();

        // Pointer at 3, clients 3 and 0 contend, pointer ends at 1.
        load_rand(2);
        tick();
        load_rand(3);
        load_rand(0);
        tick();
        tick();
        for (int c = 0; c < NCLI; c++) load_rand(c);
        repeat (4) tick();
        repeat (3) tick();

        // Zero and one operands back-to-back from the same client.
        load(1, 4'h5, 27'h0, 27'h123_4567);
        tick();
        load(1, 4'h6, 27'h1, 27'h123_4567);
        tick();
        chk("t5_vld0", 64'(cli_out[1].vld), 64'h1);
        chk("t5_prod0", 64'(cli_out[1].prod), 64'h0);
        tick();
        chk("t5_vld1", 64'(cli_out[1].vld), 64'h1);
        chk("t5_prod1", 64'(cli_out[1].prod), 64'h123_4567);
        repeat (2) tick();

        // Reset with results in flight: nothing may emerge afterwards.
        load_rand(0);
        load_rand(1);
        tick();
        #2;
        reset_n = 1'b0;
        for (int c = 0; c < NCLI; c++) cli_in[c].req = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        load_rand(2);
        load_rand(0);
        tick();
        repeat (3) tick();

        // Busy counter: 10 grants, then clear coinciding with a grant.
        reset_pulse();
        for (int i = 0; i < 10; i++) begin
            load_rand(i % NCLI);
            tick();
        end
`ifdef MUL_SRV_STAT_EN
        chk("t6_stat10", 64'(stat_busy), 64'd10);
`else
        chk("t6_stat10", 64'(stat_busy), 64'd0);
`endif
        load_rand(0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("t6_stat_clr", 64'(stat_busy), 64'd0);
        repeat (3) tick();

        chk("drain", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
